fft16_sequencer: RTL and testbench
==================================

# fft16_sequencer

Control sequencer for the 16-point radix-2 CORDIC FFT. On a start pulse it schedules all 32 butterfly operations: 4 stages of 8 butterflies, one issued per clock. For each butterfly it drives the in-place data-memory read addresses and the twiddle angle (`zangle`) into the butterfly/CORDIC datapath. It then drives the matching write-back addresses after a configurable datapath latency. Between stages it drains the pipeline so that no butterfly reads data that is still in flight. It sits between the sample RAM and the butterfly unit and is the only block that sequences the FFT.

## Interface
Parameters:
- `BF_LATENCY`, default 1: clock cycles from butterfly issue to valid butterfly outputs. Legal range 0..7; 0 means a purely combinational butterfly.
- `ANGLE_STEP`, default 268435456: `zangle` units per twiddle index, i.e. 2π/16 where 2^32 represents 2π.

Ports:
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle request to begin a 16-point FFT. Sampled only in IDLE.
- `busy` output 1: high while butterflies are issuing or draining.
- `done` output 1: one-cycle pulse after the final write-back.
- `bf_valid` output 1: high in each butterfly issue cycle.
- `rd_addr_a` output 4: address of the upper butterfly operand.
- `rd_addr_b` output 4: address of the lower butterfly operand.
- `zangle` output 32 (signed): twiddle angle for the current issue.
- `stage` output 2: stage of the current issue.
- `wr_en` output 1: write-back strobe for both butterfly outputs.
- `wr_addr_a` output 4: write address for `xout1`/`yout1`.
- `wr_addr_b` output 4: write address for `xout2`/`yout2`.

## Operation
- Input data is stored bit-reversed in RAM; the FFT is in-place, decimation-in-time.
- FSM states and transitions:
  - IDLE → RUN when `start` = 1.
  - RUN issues 8 butterflies, k = 0..7, one per cycle, with `bf_valid` = 1.
  - After k = 7: if `BF_LATENCY` = 0, go to RUN of the next stage, or to FIN after stage 3; otherwise go to DRAIN.
  - DRAIN waits `BF_LATENCY` cycles, then goes to RUN of the next stage, or to FIN after stage 3.
  - FIN lasts one cycle with `done` = 1, then returns to IDLE.
- Address generation for stage s (0..3) and butterfly index k (0..7):
  - half = 1<<s; group = k>>s; pos = k & (half−1).
  - `rd_addr_a` = group·2·half + pos; `rd_addr_b` = `rd_addr_a` + half.
  - All arithmetic is 4-bit unsigned and never wraps.
- Twiddle: tw = pos<<(3−s), range 0..7; `zangle` = tw·`ANGLE_STEP`, computed in 32 bits.
  - tw = 0 gives `zangle` = 0, which selects the butterfly's unrotated add/subtract path.
- Write-back: `{bf_valid, rd_addr_a, rd_addr_b}` is delayed by exactly `BF_LATENCY` cycles through a shift register; its output drives `wr_en`, `wr_addr_a` and `wr_addr_b`.
  - For `BF_LATENCY` = 0 the write path is combinational from the issue signals.
- Outside issue cycles, `rd_addr_a`, `rd_addr_b`, `zangle` and `stage` hold 0.
- `start` while busy or in FIN is ignored; there is no queueing.
- Reset:
  - `reset_n` low at any time, including mid-FFT, asynchronously forces IDLE and clears the delay line, so pending writes are discarded.
  - Reset values of all outputs are 0: `busy`, `done`, `bf_valid`, `wr_en`, all addresses, `zangle` and `stage`.
  - After release, a new `start` is required.

## Timing
- `start` is sampled at edge 0. Stage s issues in cycles 1+s·(8+L) through 8+s·(8+L), where L = `BF_LATENCY`.
- A write-back occurs L cycles after its issue. The first read of stage s+1 is one cycle after the last write of stage s, with no overlap.
- `done` occurs at cycle 4·(8+L)+1: cycle 37 for L = 1, cycle 33 for L = 0.
- `busy` is high in cycles 1 through 4·(8+L) and low in the `done` cycle.
- Throughput: one FFT per 4·(8+L)+1 cycles. A `start` in the cycle after `done` is accepted.

## Test plan
- Reset, then `start` with L = 1: bf_valid/wr_en counts are 32 each; `done` pulses exactly once at cycle 37; all outputs are 0 during reset.
- Address and angle checks:
  - stage 0, k = 0: a = 0, b = 1, `zangle` = 0.
  - stage 1, k = 3: a = 5, b = 7, `zangle` = 1073741824.
  - stage 3, k = 5: a = 5, b = 13, `zangle` = 1342177280.
- L = 3: each `wr_addr` pair equals the read pair from 3 cycles earlier; there are 3 idle cycles between stages; `done` at cycle 45.
- L = 0: `wr_en` equals `bf_valid` in the same cycle; issue is back-to-back across stages; `done` at cycle 33.
- Pulse `start` during stage 2: schedule unchanged, `done` at the nominal cycle. Drop `reset_n` at cycle 20: all outputs go to 0 immediately and no further `wr_en` occurs.
- End-to-end: bit-reversed impulse at x[0] run through fft16_sequencer, butterfly and RAM gives all 16 bins equal to x[0]. Compare a random vector against a reference DFT within CORDIC tolerance.

Source files
------------

// File: rtl/fft16_sequencer.sv
// Control sequencer for a 16-point in-place radix-2 DIT CORDIC FFT.
// Issues 32 butterflies (4 stages x 8), drives twiddle angles and delayed write-back addresses.
module fft16_sequencer #(
   parameter int          BF_LATENCY = 1,
   parameter logic [31:0] ANGLE_STEP = 32'd268435456
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               bf_valid,
   output logic [3:0]         rd_addr_a,
   output logic [3:0]         rd_addr_b,
   output logic signed [31:0] zangle,
   output logic [1:0]         stage,
   output logic               wr_en,
   output logic [3:0]         wr_addr_a,
   output logic [3:0]         wr_addr_b
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   localparam logic [2:0] DRAIN_LAST = (BF_LATENCY > 0) ? 3'(BF_LATENCY - 1) : 3'd0;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_stage, w_stage_nxt;
   logic [2:0] r_k, w_k_nxt;
   logic [2:0] r_drain, w_drain_nxt;

   logic        w_issue;
   logic [3:0]  w_kx, w_half, w_pos, w_group, w_base, w_a, w_b, w_tw;
   logic [31:0] w_angle;
   logic [8:0]  w_issue_word, w_wb;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_stage <= 2'd0;
         r_k     <= 3'd0;
         r_drain <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_k     <= w_k_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_k_nxt     = r_k;
      w_drain_nxt = r_drain;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_stage_nxt = 2'd0;
               w_k_nxt     = 3'd0;
            end
         end
         S_RUN: begin
            w_k_nxt = r_k + 3'd1;
            if (r_k == 3'd7) begin
               // With a combinational butterfly nothing is in flight, so skip the drain.
               if (BF_LATENCY != 0) begin
                  w_state_nxt = S_DRAIN;
                  w_drain_nxt = 3'd0;
               end else if (r_stage == 2'd3) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_stage_nxt = r_stage + 2'd1;
               end
            end
         end
         S_DRAIN: begin
            if (r_drain == DRAIN_LAST) begin
               w_drain_nxt = 3'd0;
               if (r_stage == 2'd3) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_RUN;
                  w_stage_nxt = r_stage + 2'd1;
               end
            end else begin
               w_drain_nxt = r_drain + 3'd1;
            end
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // In-place addressing: a = group*2*half + pos, b = a + half; twiddle = pos << (3-s).
   assign w_issue = (r_state == S_RUN);
   assign w_kx    = {1'b0, r_k};
   assign w_half  = 4'd1 << r_stage;
   assign w_pos   = w_kx & (w_half - 4'd1);
   assign w_group = w_kx >> r_stage;
   assign w_base  = (w_group << r_stage) << 1;
   assign w_a     = w_base + w_pos;
   assign w_b     = w_a + w_half;
   assign w_tw    = w_pos << (2'd3 - r_stage);
   assign w_angle = {28'd0, w_tw} * ANGLE_STEP;

   assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign done      = (r_state == S_FIN);
   assign bf_valid  = w_issue;
   assign rd_addr_a = w_issue ? w_a : 4'd0;
   assign rd_addr_b = w_issue ? w_b : 4'd0;
   assign zangle    = w_issue ? signed'(w_angle) : 32'sd0;
   assign stage     = w_issue ? r_stage : 2'd0;

   assign w_issue_word = {w_issue, rd_addr_a, rd_addr_b};

   generate
      if (BF_LATENCY == 0) begin : g_wb_comb
         assign w_wb = w_issue_word;
      end else begin : g_wb_dly
         logic [8:0] r_dly [BF_LATENCY];
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < BF_LATENCY; i++) r_dly[i] <= 9'd0;
            end else begin
               r_dly[0] <= w_issue_word;
               for (int i = 1; i < BF_LATENCY; i++) r_dly[i] <= r_dly[i-1];
            end
         end
         assign w_wb = r_dly[BF_LATENCY-1];
      end
   endgenerate

   assign wr_en     = w_wb[8];
   assign wr_addr_a = w_wb[7:4];
   assign wr_addr_b = w_wb[3:0];

endmodule

// File: tb/tb_fft16_sequencer.sv
// Scoreboard bench for fft16_sequencer: three instances (latency 1, 3, 0) run one at a time;
// expected issue/write/done events are queued at start and popped by a negedge monitor.
module tb_fft16_sequencer;

   localparam int ANG = 268435456;

   typedef struct {
      int d;
      int c;
      int a;
      int b;
      int s;
      int z;
   } rec_t;

   logic               clock = 1'b0;
   logic               reset_n;
   logic [2:0]         start;
   logic [2:0]         busy, done, bf_valid, wr_en;
   logic [3:0]         rd_a [3];
   logic [3:0]         rd_b [3];
   logic [3:0]         wa   [3];
   logic [3:0]         wb   [3];
   logic signed [31:0] zang [3];
   logic [1:0]         stg  [3];

   int   LAT [3] = '{1, 3, 0};
   // Hand-derived butterfly table, stage-major (index = s*8 + k).
   int   TA  [32] = '{0,2,4,6,8,10,12,14,  0,1,4,5,8,9,12,13,
                      0,1,2,3,8,9,10,11,   0,1,2,3,4,5,6,7};
   int   TB  [32] = '{1,3,5,7,9,11,13,15,  2,3,6,7,10,11,14,15,
                      4,5,6,7,12,13,14,15, 8,9,10,11,12,13,14,15};
   int   TW  [32] = '{0,0,0,0,0,0,0,0,     0,4,0,4,0,4,0,4,
                      0,2,4,6,0,2,4,6,     0,1,2,3,4,5,6,7};

   rec_t iq[$], wq[$], dq[$];
   rec_t mr;
   int   cyc = 0;
   int   t0  = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   bw_lo [3] = '{1000000, 1000000, 1000000};
   int   bw_hi [3] = '{-1, -1, -1};
   int   cnt_v [3] = '{0, 0, 0};
   int   cnt_w [3] = '{0, 0, 0};
   int   cnt_d [3] = '{0, 0, 0};

   fft16_sequencer #(.BF_LATENCY(1)) u_l1 (
      .clock(clock), .reset_n(reset_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .bf_valid(bf_valid[0]), .rd_addr_a(rd_a[0]), .rd_addr_b(rd_b[0]), .zangle(zang[0]),
      .stage(stg[0]), .wr_en(wr_en[0]), .wr_addr_a(wa[0]), .wr_addr_b(wb[0]));

   fft16_sequencer #(.BF_LATENCY(3)) u_l3 (
      .clock(clock), .reset_n(reset_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .bf_valid(bf_valid[1]), .rd_addr_a(rd_a[1]), .rd_addr_b(rd_b[1]), .zangle(zang[1]),
      .stage(stg[1]), .wr_en(wr_en[1]), .wr_addr_a(wa[1]), .wr_addr_b(wb[1]));

   fft16_sequencer #(.BF_LATENCY(0)) u_l0 (
      .clock(clock), .reset_n(reset_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .bf_valid(bf_valid[2]), .rd_addr_a(rd_a[2]), .rd_addr_b(rd_b[2]), .zangle(zang[2]),
      .stage(stg[2]), .wr_en(wr_en[2]), .wr_addr_a(wa[2]), .wr_addr_b(wb[2]));

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input int d, input string nm);
      chk({nm, "_ctl"}, {busy[d], done[d], bf_valid[d], wr_en[d]}, 0);
      chk({nm, "_rd"},  {rd_a[d], rd_b[d], stg[d]}, 0);
      chk({nm, "_z"},   zang[d], 0);
      chk({nm, "_wr"},  {wa[d], wb[d]}, 0);
   endtask

   // Monitor: every cycle, compare DUT outputs against the queued expectations.
   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         chk("busy", busy[d], (cyc >= bw_lo[d] && cyc <= bw_hi[d]));
         if (bf_valid[d]) begin
            cnt_v[d]++;
            if (iq.size() == 0) chk("unexpected_issue", 1, 0);
            else begin
               mr = iq.pop_front();
               chk("issue_dut", d, mr.d);
               chk("issue_cycle", cyc, mr.c);
               chk("rd_addr_a", rd_a[d], mr.a);
               chk("rd_addr_b", rd_b[d], mr.b);
               chk("stage", stg[d], mr.s);
               chk("zangle", zang[d], mr.z);
            end
         end else begin
            chk("idle_rd_zero", {rd_a[d], rd_b[d], stg[d]}, 0);
            chk("idle_zangle_zero", zang[d], 0);
         end
         if (wr_en[d]) begin
            cnt_w[d]++;
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               mr = wq.pop_front();
               chk("wr_dut", d, mr.d);
               chk("wr_cycle", cyc, mr.c);
               chk("wr_addr_a", wa[d], mr.a);
               chk("wr_addr_b", wb[d], mr.b);
            end
         end
         if (done[d]) begin
            cnt_d[d]++;
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               mr = dq.pop_front();
               chk("done_dut", d, mr.d);
               chk("done_cycle", cyc, mr.c);
            end
         end
      end
      chk("l0_wr_en_eq_bf_valid", wr_en[2], bf_valid[2]);
      if (bf_valid[2]) chk("l0_wr_addr_same_cycle", {wa[2], wb[2]}, {rd_a[2], rd_b[2]});
   end

   task automatic run_fft(input int d);
      int L;
      int i;
      L = LAT[d];
      @(negedge clock);
      start[d] = 1'b1;
      t0 = cyc + 1;
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 8; k++) begin
            i = s * 8 + k;
            iq.push_back('{d, t0 + s * (8 + L) + k, TA[i], TB[i], s, TW[i] * ANG});
            wq.push_back('{d, t0 + s * (8 + L) + k + L, TA[i], TB[i], 0, 0});
         end
      end
      dq.push_back('{d, t0 + 4 * (8 + L), 0, 0, 0, 0});
      bw_lo[d] = t0;
      bw_hi[d] = t0 + 4 * (8 + L) - 1;
      cnt_v[d] = 0;
      cnt_w[d] = 0;
      cnt_d[d] = 0;
      @(negedge clock);
      start[d] = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   task automatic wait_done(input int d);
      wait_cyc(t0 + 4 * (8 + LAT[d]));
      #1;
      chk("done_seen", cnt_d[d], 1);
      chk("bf_valid_count", cnt_v[d], 32);
      chk("wr_en_count", cnt_w[d], 32);
   endtask

   initial begin
      reset_n = 1'b1;
      start   = 3'b000;
      #3 reset_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) chk_all_zero(d, "reset");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      run_fft(0);
      wait_done(0);

      // Back-to-back start right after done, with a stray start during stage 2.
      run_fft(0);
      wait_cyc(t0 + 20);
      start[0] = 1'b1;
      @(negedge clock);
      start[0] = 1'b0;
      wait_done(0);

      run_fft(1);
      wait_done(1);

      run_fft(2);
      wait_done(2);

      // Reset mid-stage-2 with a write pending in the delay line.
      run_fft(0);
      wait_cyc(t0 + 19);
      #2;
      chk("pre_reset_bf_valid", bf_valid[0], 1);
      chk("pre_reset_wr_en", wr_en[0], 1);
      reset_n = 1'b0;
      iq.delete();
      wq.delete();
      dq.delete();
      bw_hi[0] = -1;
      #1;
      chk_all_zero(0, "async_reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (30) @(negedge clock);
      #1;

      chk("issue_queue_left", iq.size(), 0);
      chk("write_queue_left", wq.size(), 0);
      chk("done_queue_left", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
